// File: rtl/bus_arb_pkg.sv
// Shared types for the select-bus arbitration sequencer: FSM states and agent IDs.
package bus_arb_pkg;
    localparam int ID_WIDTH = 4;

    typedef logic [ID_WIDTH-1:0] agent_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        TENURE,
        TURN
    } arb_state_t;
endpackage

// File: rtl/bus_arbitration_controller_if.sv
// Select-bus handshake bundle; slave is the central sequencer, master is the agent side.
interface bus_arbitration_controller_if;
    import bus_arb_pkg::*;

    logic      bus_request;
    agent_id_t select;
    logic      bus_release;
    logic      arb_enable;
    agent_id_t owner_id;
    logic      owner_valid;
    logic      bus_busy;
    logic      timeout;

    modport master (
        output bus_request, select, bus_release,
        input  arb_enable, owner_id, owner_valid, bus_busy, timeout
    );

    modport slave (
        input  bus_request, select, bus_release,
        output arb_enable, owner_id, owner_valid, bus_busy, timeout
    );
endinterface

// File: rtl/bus_arbitration_controller_timer.sv
// Loadable down-counter: start loads, clear zeroes, enable decrements; expire flags zero.
module arb_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_load,
    output logic             o_expire
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= i_load;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expire = (r_count == '0);
endmodule

// File: rtl/bus_arbitration_controller.sv
// Central sequencer for the wired-AND select bus: opens the arbitration window,
// latches the winner, times its tenure and inserts a turnaround cycle.
module bus_arbitration_controller
    import bus_arb_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    bus_arbitration_controller_if.slave   bus
);
    // Timers load N-1 so the expire flag marks the last cycle spent in the state.
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] TENURE_LOAD = 16'(TIMEOUT_CYCLES - 1);

    arb_state_t r_state;
    agent_id_t  r_owner_id;
    logic       r_arb_enable;
    logic       r_owner_valid;
    logic       r_bus_busy;
    logic       r_timeout;

    logic w_settle_start;
    logic w_settle_expire;
    logic w_tenure_start;
    logic w_tenure_expire;

    assign w_settle_start = (r_state == IDLE) && bus.bus_request;
    assign w_tenure_start = (r_state == ARB) && w_settle_expire && bus.bus_request;

    arb_timer #(.WIDTH(4)) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_settle_start),
        .i_clear  (r_state != ARB),
        .i_enable (r_state == ARB),
        .i_load   (SETTLE_LOAD),
        .o_expire (w_settle_expire)
    );

    arb_timer #(.WIDTH(16)) u_tenure_timer (
        .clk      (clk),
        .reset    (reset),
        .i_start  (w_tenure_start),
        .i_clear  (r_state != TENURE),
        .i_enable (r_state == TENURE),
        .i_load   (TENURE_LOAD),
        .o_expire (w_tenure_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner_id    <= '0;
            r_arb_enable  <= 1'b0;
            r_owner_valid <= 1'b0;
            r_bus_busy    <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.bus_request) begin
                        r_state      <= ARB;
                        r_arb_enable <= 1'b1;
                        r_bus_busy   <= 1'b1;
                    end
                end
                ARB: begin
                    // Request level only matters in the sampling cycle.
                    if (w_settle_expire) begin
                        r_owner_id   <= ~bus.select;
                        r_arb_enable <= 1'b0;
                        if (bus.bus_request) begin
                            r_state       <= TENURE;
                            r_owner_valid <= 1'b1;
                        end else begin
                            r_state    <= IDLE;
                            r_bus_busy <= 1'b0;
                        end
                    end
                end
                TENURE: begin
                    if (bus.bus_release) begin
                        r_state       <= TURN;
                        r_owner_valid <= 1'b0;
                    end else if (w_tenure_expire) begin
                        r_state       <= TURN;
                        r_owner_valid <= 1'b0;
                        r_timeout     <= 1'b1;
                    end
                end
                TURN: begin
                    r_state    <= IDLE;
                    r_bus_busy <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.arb_enable  = r_arb_enable;
    assign bus.owner_id    = r_owner_id;
    assign bus.owner_valid = r_owner_valid;
    assign bus.bus_busy    = r_bus_busy;
    assign bus.timeout     = r_timeout;
endmodule

// File: tb/tb_bus_arbitration_controller.sv
// Directed bench for bus_arbitration_controller (SETTLE_CYCLES=2, TIMEOUT_CYCLES=8):
// expected output vectors are queued with each stimulus step and compared after the edge.
module tb_bus_arbitration_controller;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];

    bus_arbitration_controller_if bif ();

    bus_arbitration_controller #(
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {arb_enable, owner_id[3:0], owner_valid, bus_busy, timeout}
    function automatic logic [7:0] ev(input logic ae, input logic [3:0] id,
                                      input logic ov, input logic bb, input logic to);
        return {ae, id, ov, bb, to};
    endfunction

    function automatic logic [7:0] st_idle(input logic [3:0] id);
        return ev(1'b0, id, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [7:0] st_arb(input logic [3:0] id);
        return ev(1'b1, id, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic logic [7:0] st_ten(input logic [3:0] id);
        return ev(1'b0, id, 1'b1, 1'b1, 1'b0);
    endfunction
    function automatic logic [7:0] st_turn(input logic [3:0] id);
        return ev(1'b0, id, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic logic [7:0] st_tout(input logic [3:0] id);
        return ev(1'b0, id, 1'b0, 1'b1, 1'b1);
    endfunction

    task automatic check_out();
        sb_t        s;
        logic [7:0] obs;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            s   = sb_q.pop_front();
            obs = {bif.arb_enable, bif.owner_id, bif.owner_valid, bif.bus_busy, bif.timeout};
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL %s observed=%b expected=%b", s.tag, obs, s.exp);
            end
        end
    endtask

    task automatic check_now(input logic [7:0] e, input string tag);
        sb_q.push_back('{tag, e});
        check_out();
    endtask

    task automatic step(input logic req, input logic [3:0] sel, input logic rel,
                        input logic [7:0] e, input string tag);
        bif.bus_request = req;
        bif.select      = sel;
        bif.bus_release = rel;
        sb_q.push_back('{tag, e});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        bif.bus_request = 1'b0;
        bif.select      = 4'b1111;
        bif.bus_release = 1'b0;
        @(posedge clk);
        #1;
        check_now(st_idle(4'd0), "reset_state");
        reset = 1'b0;

        // Single agent ID 5
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd0),  "t1_arb_open");
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd0),  "t1_arb_last");
        step(1'b1, 4'b1010, 1'b0, st_ten(4'd5),  "t1_grant");
        step(1'b0, 4'b1010, 1'b0, st_ten(4'd5),  "t1_tenure_a");
        step(1'b0, 4'b1010, 1'b0, st_ten(4'd5),  "t1_tenure_b");
        step(1'b0, 4'b1010, 1'b1, st_turn(4'd5), "t1_release");
        step(1'b0, 4'b1010, 1'b0, st_idle(4'd5), "t1_idle");
        step(1'b0, 4'b1010, 1'b1, st_idle(4'd5), "release_in_idle");

        // Two contenders 9 and 6, request held through release
        step(1'b1, 4'b0110, 1'b0, st_arb(4'd5),  "t2_arb_open");
        step(1'b1, 4'b0110, 1'b0, st_arb(4'd5),  "t2_arb_last");
        step(1'b1, 4'b0110, 1'b0, st_ten(4'd9),  "t2_grant");
        step(1'b1, 4'b0110, 1'b0, st_ten(4'd9),  "t2_tenure");
        step(1'b1, 4'b0110, 1'b1, st_turn(4'd9), "t2_release");
        step(1'b1, 4'b0110, 1'b0, st_idle(4'd9), "t2_idle");
        step(1'b1, 4'b0110, 1'b0, st_arb(4'd9),  "t2_reopen");
        step(1'b1, 4'b0110, 1'b0, st_arb(4'd9),  "t2_arb_last");
        step(1'b0, 4'b0110, 1'b0, st_idle(4'd9), "t2_drop_last_arb");
        step(1'b0, 4'b0110, 1'b0, st_idle(4'd9), "t2_no_grant");

        // Agent 0, early request drop ignored, then timeout
        step(1'b1, 4'b1111, 1'b0, st_arb(4'd9),  "t3_arb_open");
        step(1'b0, 4'b1111, 1'b0, st_arb(4'd9),  "t3_early_drop");
        step(1'b1, 4'b1111, 1'b0, st_ten(4'd0),  "t3_id0_grant");
        for (int i = 0; i < 7; i++)
            step(1'b0, 4'b1111, 1'b0, st_ten(4'd0), "t3_tenure");
        step(1'b0, 4'b1111, 1'b0, st_tout(4'd0), "t3_timeout_pulse");
        step(1'b0, 4'b1111, 1'b0, st_idle(4'd0), "t3_timeout_clear");
        step(1'b0, 4'b1111, 1'b0, st_idle(4'd0), "t3_idle_hold");

        // Release on the final tenure cycle beats the timeout
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd0),  "t4_arb_open");
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd0),  "t4_arb_last");
        step(1'b1, 4'b1010, 1'b0, st_ten(4'd5),  "t4_grant");
        for (int i = 0; i < 7; i++)
            step(1'b0, 4'b1010, 1'b0, st_ten(4'd5), "t4_tenure");
        step(1'b0, 4'b1010, 1'b1, st_turn(4'd5), "t4_release_at_final");
        step(1'b0, 4'b1010, 1'b0, st_idle(4'd5), "t4_idle");

        // Asynchronous reset in the middle of tenure
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd5),  "t5_arb_open");
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd5),  "t5_arb_last");
        step(1'b1, 4'b1010, 1'b0, st_ten(4'd5),  "t5_grant");
        step(1'b1, 4'b1010, 1'b0, st_ten(4'd5),  "t5_tenure");
        #2;
        reset = 1'b1;
        #1;
        check_now(st_idle(4'd0), "t5_reset_async");
        @(posedge clk);
        #1;
        check_now(st_idle(4'd0), "t5_reset_held");
        reset = 1'b0;
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd0),  "t5_post_reset_arb");
        step(1'b1, 4'b1010, 1'b0, st_arb(4'd0),  "t5_post_reset_last");
        step(1'b1, 4'b1010, 1'b0, st_ten(4'd5),  "t5_post_reset_grant");

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
